// File: rtl/wbu_csr_regfile_ysyx_23060136_pkg.sv
// csr_pkg_ysyx_23060136: shared CSR indices, op codes, mstatus layout and FSM states
package csr_pkg_ysyx_23060136;
  localparam logic [2:0] CSR_NONE      = 3'd0;
  localparam logic [2:0] CSR_MSTATUS   = 3'd1;
  localparam logic [2:0] CSR_MTVEC     = 3'd2;
  localparam logic [2:0] CSR_MEPC      = 3'd3;
  localparam logic [2:0] CSR_MCAUSE    = 3'd4;
  localparam logic [2:0] CSR_MVENDORID = 3'd5;
  localparam logic [2:0] CSR_MARCHID   = 3'd6;
  localparam logic [2:0] CSR_MCYCLE    = 3'd7;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_RW    = 3'd1,
    OP_RS    = 3'd2,
    OP_RC    = 3'd3,
    OP_ECALL = 3'd4,
    OP_MRET  = 3'd5
  } csr_op_e;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam logic [31:0] MSTATUS_MASK = 32'h0000_1888;
  localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;
  localparam logic [31:0] MCAUSE_ECALL = 32'd11;
  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;
endpackage

// File: rtl/wbu_csr_regfile_ysyx_23060136_alu.sv
// csr_alu_ysyx_23060136: RW/RS/RC new-value computation with per-index write masking
module csr_alu_ysyx_23060136
  import csr_pkg_ysyx_23060136::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [2:0]      idx,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] new_val,
  output logic            we
);
  logic [XLEN-1:0] raw;
  always_comb begin
    raw = op == OP_RW ? wdata : op == OP_RS ? (old | wdata) : (old & ~wdata);
    we = (op == OP_RW || op == OP_RS || op == OP_RC) &&
         (idx inside {CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE});
    new_val = idx == CSR_MSTATUS ? ((raw & XLEN'(MSTATUS_MASK)) | XLEN'(MSTATUS_MPP)) :
              (idx == CSR_MTVEC || idx == CSR_MEPC) ? {raw[XLEN-1:2], 2'b00} : raw;
  end
endmodule

// File: rtl/wbu_csr_regfile_ysyx_23060136.sv
// wbu_csr_regfile_ysyx_23060136: machine-mode CSR file with commit-time updates and trap redirect
module wbu_csr_regfile_ysyx_23060136
  import csr_pkg_ysyx_23060136::*;
#(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] MVENDORID_VAL = 32'h7973_7978,
  parameter logic [XLEN-1:0] MARCHID_VAL   = 32'h015F_DEA8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      csr_rs_idx,
  output logic [XLEN-1:0] csr_rs_rdata,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [2:0]      commit_op,
  input  logic [2:0]      commit_rd_idx,
  input  logic [XLEN-1:0] commit_wdata,
  input  logic [XLEN-1:0] commit_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);
  state_e state_q, state_d;
  logic [XLEN-1:0] mstatus, mtvec, mepc, mcause, new_val;
  logic [63:0] mcycle;
  logic [XLEN-1:0] csr_file [8];
  logic fire, we;
  assign fire = commit_valid && commit_ready;
  always_comb begin
    csr_file[CSR_NONE]      = '0;
    csr_file[CSR_MSTATUS]   = mstatus;
    csr_file[CSR_MTVEC]     = mtvec;
    csr_file[CSR_MEPC]      = mepc;
    csr_file[CSR_MCAUSE]    = mcause;
    csr_file[CSR_MVENDORID] = MVENDORID_VAL;
    csr_file[CSR_MARCHID]   = MARCHID_VAL;
    csr_file[CSR_MCYCLE]    = mcycle[XLEN-1:0];
  end
  assign csr_rs_rdata = csr_file[csr_rs_idx];
  csr_alu_ysyx_23060136 #(.XLEN(XLEN)) u_alu (
    .op     (commit_op),
    .idx    (commit_rd_idx),
    .old    (csr_file[commit_rd_idx]),
    .wdata  (commit_wdata),
    .new_val(new_val),
    .we     (we)
  );
  always_ff @(posedge clk) state_q <= rst ? ST_IDLE : state_d;
  always_comb
    state_d = state_q == ST_FLUSH ? ST_IDLE :
              (fire && (commit_op == OP_ECALL || commit_op == OP_MRET)) ? ST_FLUSH : ST_IDLE;
  always_comb begin
    commit_ready   = state_q == ST_IDLE;
    redirect_valid = state_q == ST_FLUSH;
  end
  always_ff @(posedge clk) mcycle <= rst ? '0 : mcycle + 64'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus     <= XLEN'(MSTATUS_MPP);
      mtvec       <= '0;
      mepc        <= '0;
      mcause      <= '0;
      redirect_pc <= '0;
    end else if (fire) begin
      if (commit_op == OP_ECALL) begin
        mepc              <= {commit_pc[XLEN-1:2], 2'b00};
        mcause            <= XLEN'(MCAUSE_ECALL);
        mstatus[MPIE_BIT] <= mstatus[MIE_BIT];
        mstatus[MIE_BIT]  <= 1'b0;
        redirect_pc       <= mtvec;
      end else if (commit_op == OP_MRET) begin
        mstatus[MIE_BIT]  <= mstatus[MPIE_BIT];
        mstatus[MPIE_BIT] <= 1'b1;
        redirect_pc       <= mepc;
      end else if (we) begin
        if (commit_rd_idx == CSR_MSTATUS) mstatus <= new_val;
        if (commit_rd_idx == CSR_MTVEC) mtvec <= new_val;
        if (commit_rd_idx == CSR_MEPC) mepc <= new_val;
        if (commit_rd_idx == CSR_MCAUSE) mcause <= new_val;
      end
    end
  end
endmodule

// File: tb/tb_wbu_csr_regfile_ysyx_23060136.sv
// tb_wbu_csr_regfile_ysyx_23060136: directed checks of CSR reads, writes, ecall/mret and reset
module tb_wbu_csr_regfile_ysyx_23060136;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] csr_rs_idx = '0;
  logic [31:0] csr_rs_rdata;
  logic commit_valid = 1'b0;
  logic commit_ready;
  logic [2:0] commit_op = '0;
  logic [2:0] commit_rd_idx = '0;
  logic [31:0] commit_wdata = '0;
  logic [31:0] commit_pc = '0;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  int checks = 0;
  int passed = 0;
  logic [31:0] cyc_a;
  wbu_csr_regfile_ysyx_23060136 dut (
    .clk           (clk),
    .rst           (rst),
    .csr_rs_idx    (csr_rs_idx),
    .csr_rs_rdata  (csr_rs_rdata),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .commit_op     (commit_op),
    .commit_rd_idx (commit_rd_idx),
    .commit_wdata  (commit_wdata),
    .commit_pc     (commit_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string tag);
    csr_rs_idx = idx;
    #1;
    check(tag, csr_rs_rdata, exp);
  endtask
  task automatic commit(input logic [2:0] op, input logic [2:0] idx, input logic [31:0] wd, input logic [31:0] pc);
    commit_valid = 1'b1;
    commit_op = op;
    commit_rd_idx = idx;
    commit_wdata = wd;
    commit_pc = pc;
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
  endtask
  task automatic ctrl(input logic rv, input logic cr, input logic [31:0] pc, input string tag);
    check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
    check({tag, ".commit_ready"}, 32'(commit_ready), 32'(cr));
    check({tag, ".redirect_pc"}, redirect_pc, pc);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ctrl(1'b0, 1'b1, 32'h0, "reset");
    rd(3'd0, 32'h0, "rst_none");
    rd(3'd1, 32'h0000_1800, "rst_mstatus");
    rd(3'd2, 32'h0, "rst_mtvec");
    rd(3'd3, 32'h0, "rst_mepc");
    rd(3'd4, 32'h0, "rst_mcause");
    rd(3'd5, 32'h7973_7978, "mvendorid");
    rd(3'd6, 32'h015F_DEA8, "marchid");
    rd(3'd7, 32'h0, "rst_mcycle");
    csr_rs_idx = 3'd2;
    commit_valid = 1'b1;
    commit_op = 3'd1;
    commit_rd_idx = 3'd2;
    commit_wdata = 32'h8000_0103;
    #1 check("mtvec_no_fwd", csr_rs_rdata, 32'h0);
    @(posedge clk);
    #1 commit_valid = 1'b0;
    rd(3'd2, 32'h8000_0100, "mtvec_rw");
    commit(3'd2, 3'd1, 32'hFFFF_FFFF, 32'h0);
    rd(3'd1, 32'h0000_1888, "mstatus_rs");
    commit(3'd3, 3'd1, 32'h8, 32'h0);
    rd(3'd1, 32'h0000_1880, "mstatus_rc");
    commit(3'd1, 3'd3, 32'hFFFF_FFFF, 32'h0);
    rd(3'd3, 32'hFFFF_FFFC, "mepc_rw");
    commit(3'd1, 3'd4, 32'hFFFF_FFFF, 32'h0);
    rd(3'd4, 32'hFFFF_FFFF, "mcause_rw");
    commit(3'd6, 3'd4, 32'h0, 32'h0);
    rd(3'd4, 32'hFFFF_FFFF, "op6_none");
    commit(3'd0, 3'd4, 32'h0, 32'h0);
    rd(3'd4, 32'hFFFF_FFFF, "op_none");
    commit(3'd2, 3'd1, 32'h8, 32'h0);
    rd(3'd1, 32'h0000_1888, "mie_set");
    commit(3'd4, 3'd0, 32'h0, 32'h8000_0024);
    ctrl(1'b1, 1'b0, 32'h8000_0100, "ecall");
    rd(3'd3, 32'h8000_0024, "ecall_mepc");
    rd(3'd4, 32'd11, "ecall_mcause");
    rd(3'd1, 32'h0000_1880, "ecall_mstatus");
    commit_valid = 1'b1;
    commit_op = 3'd5;
    @(posedge clk);
    #1 ctrl(1'b0, 1'b1, 32'h8000_0100, "ecall_done");
    rd(3'd1, 32'h0000_1880, "mret_stalled");
    @(posedge clk);
    #1 commit_valid = 1'b0;
    ctrl(1'b1, 1'b0, 32'h8000_0024, "mret");
    rd(3'd1, 32'h0000_1888, "mret_mstatus");
    @(posedge clk);
    #1 commit(3'd4, 3'd0, 32'h0, 32'h8000_0036);
    ctrl(1'b1, 1'b0, 32'h8000_0100, "ecall2");
    rd(3'd3, 32'h8000_0034, "ecall2_mepc");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ctrl(1'b0, 1'b1, 32'h0, "flush_rst");
    rd(3'd1, 32'h0000_1800, "frst_mstatus");
    rd(3'd2, 32'h0, "frst_mtvec");
    rd(3'd3, 32'h0, "frst_mepc");
    rd(3'd4, 32'h0, "frst_mcause");
    @(posedge clk);
    #1 check("frst_no_redirect", 32'(redirect_valid), 32'h0);
    commit(3'd1, 3'd6, 32'hFFFF_FFFF, 32'h0);
    rd(3'd6, 32'h015F_DEA8, "marchid_ro");
    commit(3'd1, 3'd0, 32'hFFFF_FFFF, 32'h0);
    rd(3'd0, 32'h0, "none_ro");
    csr_rs_idx = 3'd7;
    #1 cyc_a = csr_rs_rdata;
    commit(3'd1, 3'd7, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    #1 check("mcycle_delta", csr_rs_rdata - cyc_a, 32'd5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/wbu_csr_regfile_ysyx_23060136.md
Name: wbu_csr_regfile_ysyx_23060136

Overview:
- Machine-mode CSR register file, directly downstream of the IDU CSR decoder.
- Consumes its 3-bit CSR indices: the source index drives the combinational read port; the destination index, carried down the pipe, selects the write target at commit.
- Executes csrrw/csrrs/csrrc, ecall and mret side effects when WBU commits.
- Issues a registered one-cycle redirect to IFU for trap entry and return.

Parameters:
- XLEN, 32, CSR and PC data width.
- MVENDORID_VAL, 32'h7973_7978, constant returned for mvendorid.
- MARCHID_VAL, 32'h015F_DEA8, constant returned for marchid (23060136).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- csr_rs_idx  input  3  read index from IDU CSR decode.
- csr_rs_rdata  output  XLEN  combinational read data.
- commit_valid  input  1  WBU presents a CSR-affecting commit.
- commit_ready  output  1  block can accept a commit this cycle.
- commit_op  input  3  csr_op_e operation.
- commit_rd_idx  input  3  write index, from IDU csr_rd.
- commit_wdata  input  XLEN  operand: rs1 value or zero-extended zimm.
- commit_pc  input  XLEN  PC of the committing instruction.
- redirect_valid  output  1  one-cycle redirect pulse.
- redirect_pc  output  XLEN  redirect target.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high; all state updates on the rising edge of clk.
- Index map (pkg):
  - 0 none, 1 mstatus, 2 mtvec, 3 mepc, 4 mcause, 5 mvendorid, 6 marchid, 7 mcycle (low 32 bits).
  - Index 0 reads 0.
- Reset values:
  - mstatus = 32'h0000_1800 (MPP=11); mtvec = 0; mepc = 0; mcause = 0; mcycle = 0.
  - FSM = IDLE; redirect_valid = 0; redirect_pc = 0; commit_ready = 1 once the FSM is in IDLE.
- mcycle: 64-bit counter, +1 every non-reset cycle, wraps 2^64-1 to 0. It is read-only.
- Read: csr_rs_rdata is purely combinational from csr_rs_idx. A same-cycle write is not forwarded; the old value is visible until the next edge.
- Handshake: a commit is accepted when commit_valid and commit_ready are both high. Inputs are sampled only then; all register updates occur at that edge.
- Write ops (target commit_rd_idx, old = current value):
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - NONE: no effect.
- Write masking:
  - mstatus: only bits 3 (MIE), 7 (MPIE) and 12:11 (MPP) are stored. MPP is hardwired to 11; all other bits read 0.
  - mtvec and mepc: bits [1:0] are forced to 0.
  - mcause: full width is writable.
  - Indices 0, 5, 6, 7: writes are silently ignored.
- ECALL (accepted), all at the same edge:
  - mepc <= {pc[31:2], 2'b00}; mcause <= 32'd11.
  - MPIE <= MIE; MIE <= 0; MPP <= 11.
  - redirect_pc <= mtvec (direct mode); FSM -> FLUSH.
- MRET (accepted):
  - MIE <= MPIE; MPIE <= 1.
  - redirect_pc <= mepc; FSM -> FLUSH.
- FSM:
  - IDLE: commit_ready = 1, redirect_valid = 0.
  - FLUSH: commit_ready = 0, redirect_valid = 1 for exactly one cycle, then unconditionally back to IDLE.
- Latency: redirect_valid asserts exactly 1 cycle after the ECALL/MRET handshake.
- A commit_valid held during FLUSH is stalled and accepted in the following IDLE cycle.
- rst asserted in FLUSH: next cycle is IDLE with redirect_valid = 0 and all CSRs at reset values. No redirect is emitted.
- Unknown commit_op codes (6, 7) are treated as NONE.

Decomposition:
- Shared package csr_pkg_ysyx_23060136 contains:
  - the CSR index localparams (replacing the global defines);
  - csr_op_e (NONE=0, RW=1, RS=2, RC=3, ECALL=4, MRET=5);
  - the mstatus bit positions and write mask 32'h0000_1888;
  - the FSM state enum (IDLE, FLUSH).
- One natural sub-module: csr_alu_ysyx_23060136, which computes the RW/RS/RC new value and applies the per-index write mask.

Test Plan:
- Reset, then read every index -> mstatus=0x1800, mtvec=mepc=mcause=0, mvendorid=0x79737978, marchid=0x015FDEA8, index 0 = 0.
- RW mtvec wdata=0x8000_0103 -> next cycle mtvec reads 0x8000_0100. The same-cycle read still shows 0.
- RS mstatus wdata=0xFFFF_FFFF -> mstatus reads 0x1888. RC wdata=0x8 -> reads 0x1880.
- With mtvec=0x8000_0100 and MIE=1, ECALL pc=0x8000_0024:
  - 1 cycle later: redirect_valid=1, redirect_pc=0x8000_0100, commit_ready=0.
  - mepc=0x8000_0024, mcause=11, mstatus=0x1880.
  - 2 cycles later: redirect_valid=0, commit_ready=1.
- Following MRET -> redirect_pc=0x8000_0024 and mstatus=0x1888. Then assert rst during a FLUSH cycle -> no further redirect, all CSRs at reset values.
- RW to marchid and mcycle -> values unchanged. mcycle read at cycles N and N+5 differs by exactly 5.
